// File: rtl/nios_cpu_xb_gpio_out.sv
// Avalon-MM output PIO for the XB control path: static DATA, atomic set/clear, and timed inversion pulses.
// Latency: writes show on out_port right after the write edge; readdata is registered, so it is valid 1 cycle after address.
// Backpressure: none (no waitrequest); every access completes in one cycle.
module nios_cpu_xb_gpio_out #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          LEN_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    localparam logic [WIDTH-1:0]     RST_OUT = RESET_VALUE[WIDTH-1:0];
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_LEN      = 3'd2;
    localparam logic [2:0] A_PULSE    = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;

    logic [WIDTH-1:0]     data_q,     data_d;
    logic [LEN_WIDTH-1:0] len_q,      len_d;
    logic [WIDTH-1:0]     active_q,   active_d;
    logic [LEN_WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0]     out_q,      out_d;
    logic [31:0]          readdata_q, readdata_d;

    logic                 wr_en;
    logic [WIDTH-1:0]     wr_bits;
    logic [LEN_WIDTH-1:0] wr_len;
    logic                 pulse_load;
    logic                 unused_wdata;

    // Write qualification and field extraction; bits above WIDTH/LEN_WIDTH are ignored.
    always_comb begin
        wr_en        = chipselect & ~write_n;
        wr_bits      = writedata[WIDTH-1:0];
        wr_len       = writedata[LEN_WIDTH-1:0];
        pulse_load   = wr_en && (address == A_PULSE) && (wr_bits != '0);
        unused_wdata = ^writedata;
    end

    // DATA and LEN register updates: plain load, atomic set, atomic clear.
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr_en) begin
            case (address)
                A_DATA:     data_d = wr_bits;
                A_OUTSET:   data_d = data_q | wr_bits;
                A_OUTCLEAR: data_d = data_q & ~wr_bits;
                A_LEN:      len_d  = wr_len;
                default:    ;
            endcase
        end
    end

    // Pulse engine: a nonzero PULSE write ORs in bits and reloads the shared counter,
    // taking priority over expiry so a retrigger on the last cycle leaves no gap.
    // The counter holds 0 whenever nothing is active, so it cannot wrap.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (pulse_load) begin
            active_d = active_q | wr_bits;
            cnt_d    = (len_q == '0) ? LEN_ONE : len_q;
        end else if (active_q != '0) begin
            if (cnt_q <= LEN_ONE) begin
                active_d = '0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q - LEN_ONE;
            end
        end
    end

    // Output uses next-state values so a write is visible right after its own edge.
    always_comb begin
        out_d = data_d ^ active_d;
    end

    // Read mux samples current register state every cycle, independent of chipselect.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            A_DATA:   readdata_d = 32'(data_q);
            A_LEN:    readdata_d = 32'(len_q);
            A_PULSE:  readdata_d = 32'(active_q);
            A_STATUS: readdata_d = {31'd0, (active_q != '0)};
            default:  readdata_d = 32'd0;
        endcase
    end

    // State registers; asynchronous reset drops any pulse in progress immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RST_OUT;
            len_q      <= LEN_ONE;
            active_q   <= '0;
            cnt_q      <= '0;
            out_q      <= RST_OUT;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            len_q      <= len_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = readdata_q;
    assign busy     = (active_q != '0);

endmodule

// File: tb/tb_nios_cpu_xb_gpio_out.sv
// Bench for nios_cpu_xb_gpio_out: directed register traffic, an end-time pulse model, per-cycle compare.
// Latency: model tracks pulse expiry as an absolute edge number rather than a counter.
// Backpressure: none; every stimulus write takes one cycle.
module tb_nios_cpu_xb_gpio_out;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: register contents plus the edge at which the pulse ends.
    logic [7:0]  m_data = 8'h00;
    logic [15:0] m_len  = 16'd1;
    logic [7:0]  m_mask = 8'h00;
    int          m_edge = 0;
    int          m_end  = 0;
    logic [31:0] m_rd   = 32'd0;
    bit          cmp_en = 1'b0;

    nios_cpu_xb_gpio_out #(
        .WIDTH(8),
        .RESET_VALUE(32'd0),
        .LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: update on each clock edge or reset assertion from the bus inputs only.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_data = 8'h00;
                m_len  = 16'd1;
                m_mask = 8'h00;
                m_edge = 0;
                m_end  = 0;
                m_rd   = 32'd0;
            end else begin
                m_edge++;
                case (address)
                    3'd0:    m_rd = {24'd0, m_data};
                    3'd2:    m_rd = {16'd0, m_len};
                    3'd3:    m_rd = {24'd0, m_mask};
                    3'd6:    m_rd = {31'd0, (m_mask != 8'h00)};
                    default: m_rd = 32'd0;
                endcase
                if (chipselect && !write_n) begin
                    case (address)
                        3'd0: m_data = writedata[7:0];
                        3'd2: m_len  = writedata[15:0];
                        3'd3: begin
                            if (writedata[7:0] != 8'h00) begin
                                m_mask = m_mask | writedata[7:0];
                                m_end  = m_edge + ((m_len == 16'd0) ? 1 : int'(m_len));
                            end
                        end
                        3'd4: m_data = m_data | writedata[7:0];
                        3'd5: m_data = m_data & ~writedata[7:0];
                        default: ;
                    endcase
                end
                if (m_edge >= m_end) m_mask = 8'h00;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("cyc_out",  {24'd0, out_port}, {24'd0, m_data ^ m_mask});
                chk("cyc_busy", {31'd0, busy},     {31'd0, (m_mask != 8'h00)});
                chk("cyc_rd",   readdata,          m_rd);
            end
        end
    end

    // Called at a falling edge; presents one write for the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        #3 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out",  {24'd0, out_port}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_rd",   readdata, 32'h0);
        reset_n = 1'b1;
        rd(3'd0); chk("rd_data_rst", readdata, 32'h00);
        rd(3'd2); chk("rd_len_rst",  readdata, 32'h01);

        wr(3'd0, 32'hA5); chk("data_wr",  {24'd0, out_port}, 32'hA5);
        wr(3'd4, 32'h0A); chk("outset",   {24'd0, out_port}, 32'hAF);
        wr(3'd5, 32'h81); chk("outclear", {24'd0, out_port}, 32'h2E);
        rd(3'd0); chk("rd_data", readdata, 32'h2E);

        // Three-cycle pulse on bits 0 and 4
        wr(3'd2, 32'd3);
        wr(3'd0, 32'hF0);
        wr(3'd3, 32'h11);
        chk("p3_c1", {24'd0, out_port}, 32'hE1);
        chk("p3_busy", {31'd0, busy}, 32'h1);
        @(negedge clk);
        chk("p3_c2", {24'd0, out_port}, 32'hE1);
        chk("p3_active", readdata, 32'h11);
        @(negedge clk);
        chk("p3_c3", {24'd0, out_port}, 32'hE1);
        @(negedge clk);
        chk("p3_end", {24'd0, out_port}, 32'hF0);
        chk("p3_idle", {31'd0, busy}, 32'h0);

        // Retrigger two cycles in: both bits end five cycles after the second write
        wr(3'd2, 32'd5);
        wr(3'd3, 32'h01);
        chk("rt_first", {24'd0, out_port}, 32'hF1);
        @(negedge clk);
        chk("rt_first2", {24'd0, out_port}, 32'hF1);
        wr(3'd3, 32'h02);
        chk("rt_both0", {24'd0, out_port}, 32'hF3);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rt_both%0d", i), {24'd0, out_port}, 32'hF3);
        end
        @(negedge clk);
        chk("rt_end", {24'd0, out_port}, 32'hF0);
        chk("rt_idle", {31'd0, busy}, 32'h0);

        // LEN=0 behaves as a single-cycle pulse
        wr(3'd2, 32'd0);
        wr(3'd3, 32'h04);
        chk("len0_on", {24'd0, out_port}, 32'hF4);
        @(negedge clk);
        chk("len0_off", {24'd0, out_port}, 32'hF0);

        // Asynchronous reset during a pulse
        wr(3'd2, 32'd10);
        wr(3'd3, 32'hFF);
        chk("pre_rst", {24'd0, out_port}, 32'h0F);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out",  {24'd0, out_port}, 32'h00);
        chk("arst_busy", {31'd0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd3); chk("post_rst_active", readdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("post_rst_out",  {24'd0, out_port}, 32'h00);
        chk("post_rst_busy", {31'd0, busy}, 32'h0);

        // Reserved writes and empty pulse mask are ignored
        wr(3'd0, 32'h3C);
        wr(3'd1, 32'hFF);
        wr(3'd7, 32'hFF);
        wr(3'd3, 32'h00);
        chk("ign_out",  {24'd0, out_port}, 32'h3C);
        chk("ign_busy", {31'd0, busy}, 32'h0);
        rd(3'd1); chk("rd_res1", readdata, 32'h0);
        rd(3'd4); chk("rd_set",  readdata, 32'h0);
        rd(3'd5); chk("rd_clr",  readdata, 32'h0);
        rd(3'd7); chk("rd_res7", readdata, 32'h0);
        rd(3'd2); chk("rd_len1", readdata, 32'h1);
        rd(3'd0); chk("rd_data2", readdata, 32'h3C);

        // Retrigger on the expiry edge keeps bit 0 inverted without a gap
        wr(3'd2, 32'd2);
        wr(3'd3, 32'h01);
        chk("exp_a", {24'd0, out_port}, 32'h3D);
        @(negedge clk);
        wr(3'd3, 32'h02);
        chk("exp_b", {24'd0, out_port}, 32'h3F);
        rd(3'd6); chk("exp_status", readdata, 32'h1);
        @(negedge clk);
        chk("exp_end", {24'd0, out_port}, 32'h3C);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
